binary_maxpool: RTL and testbench
=================================

Name: binary_maxpool

Overview:
- Stage directly downstream of the CONV2 result path in the controller: consumes the signed 5-bit conv2 channel sum and its `maxpool_valid` strobe.
- Performs 2x2 stride-2 max pooling over the 24x24 conv2 output map (raster order).
- Binarizes each pooled value (1 when max >= 0, else 0) and streams the 144 resulting bits, with an index, to the fully-connected stage.
- Uses a half-row line buffer, so no full-frame storage is needed.

Parameters:
- IN_W, 24, input map width (even).
- IN_H, 24, input map height (even).
- DATA_W, 5, signed width of the input sample.
- OUT_N, (IN_W/2)*(IN_H/2) = 144, pooled bits per frame (localparam).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; clears counters and line buffer for a new frame
- din  in  DATA_W  signed conv2 sum (conv2_result_sum0)
- din_valid  in  1  sample strobe (maxpool_valid)
- pool_bit  out  1  binarized pooled value
- pool_valid  out  1  one-cycle strobe qualifying pool_bit/pool_idx
- pool_idx  out  8  pooled-pixel index 0..143, raster order
- pool_done  out  1  one-cycle pulse coincident with the pool_valid of index 143
- overrun  out  1  sticky: a din_valid arrived after the frame completed

Behaviour:
- Reset: asynchronous, active-low. All outputs 0; counters 0; line buffer and pair register cleared to the most-negative value (-2^(DATA_W-1)).
- Counters:
  - col 0..IN_W-1 and row 0..IN_H-1 advance only on din_valid; col wraps to 0 and row increments.
  - Gaps in din_valid are allowed; state holds.
- Even col: pair_reg <= din.
- Odd col: pair_max = signed max(pair_reg, din).
  - Even row: linebuf[col>>1] <= pair_max.
  - Odd row: quad = signed max(pair_max, linebuf[col>>1]). Next cycle: pool_bit = ~quad[DATA_W-1], pool_valid = 1, pool_idx = (row>>1)*(IN_W/2) + (col>>1).
- Latency: one cycle from the accepted din_valid of the bottom-right pixel of a 2x2 window to pool_valid.
- Comparisons are signed throughout. Ties select either operand (the value is identical). No arithmetic widening.
- Frame end:
  - After the 576th accepted sample, the block enters DONE.
  - pool_done pulses with the final pool_valid.
  - Further din_valid is ignored and sets overrun.
  - Counters hold until frame_start.
- State machine:
  - IDLE -> RUN on frame_start.
  - RUN -> DONE on the last sample.
  - DONE -> RUN on frame_start.
  - din_valid in IDLE is ignored and does not set overrun.
- frame_start behaviour:
  - frame_start in RUN (mid-frame) aborts the frame: counters and line buffer clear, no pool_done, overrun clears.
  - frame_start and din_valid in the same cycle: frame_start wins; that sample is dropped.
- Reset mid-frame returns to IDLE with all outputs 0.

Optional Feature:
- MAXPOOL_RAW_OUT_EN defined: adds output pool_max [DATA_W-1:0], the signed quad max, registered alongside pool_bit and valid with pool_valid; it resets to 0.
- Undefined: the port and its register do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package bnn_pkg holds:
  - state encoding (IDLE/RUN/DONE)
  - CONV2_OUT_W=24, CONV2_OUT_H=24, POOL_OUT_N=144
  - the sample width constant
  - a signed max function
- One sub-module: pool_linebuf, an IN_W/2 x DATA_W register array with synchronous write, combinational read, and clear on frame_start/reset.

Test Plan:
- Reset, then frame_start, then 576 samples all +3 -> 144 pool_valid pulses, pool_bit=1 each, pool_idx 0..143 in order, pool_done with idx 143.
- All samples -1 except one 0 in the window at rows 2-3, cols 4-5 -> pool_bit=1 only at idx 14; all others 0.
- Window values {-16,-16,-16,-1} -> pool_bit=0. Window {-16,15,-16,-16} -> pool_bit=1 (signed compare check).
- Random din_valid gaps (about 50% duty) with a known pattern -> identical bit sequence to the gapless run; pool_valid is exactly 1 cycle after each odd-row/odd-col accept.
- 100 samples, then frame_start, then a full frame -> no pool_done for the aborted frame; the new frame's idx restarts at 0. An extra din_valid after pool_done -> overrun=1, no pool_valid.
- rstn asserted at sample 300 -> outputs 0 immediately; din_valid before frame_start ignored, overrun stays 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants, FSM encoding and signed max helper for the BNN pooling path
package bnn_pkg;

  localparam int CONV2_OUT_W = 24;
  localparam int CONV2_OUT_H = 24;
  localparam int POOL_OUT_N  = (CONV2_OUT_W / 2) * (CONV2_OUT_H / 2);
  localparam int CONV2_SUM_W = 5;

  // Wide enough for any sample width; callers sign-extend in and truncate out.
  localparam int SMAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - half-row buffer of horizontal pair maxima, cleared to the most-negative sample
module pool_linebuf #(
  parameter int DEPTH  = 12,
  parameter int DATA_W = 5,
  parameter int AW     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clr) begin
        mem_d[i] = S_MIN;
      end else if (we && (waddr == AW'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= S_MIN;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/binary_maxpool.sv
// rtl/binary_maxpool.sv - 2x2 stride-2 max pool + binarize of the conv2 map, streamed in raster order
// Optional MAXPOOL_RAW_OUT_EN adds pool_max, the signed window maximum.
module binary_maxpool
  import bnn_pkg::*;
#(
  parameter int IN_W   = CONV2_OUT_W,
  parameter int IN_H   = CONV2_OUT_H,
  parameter int DATA_W = CONV2_SUM_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     frame_start,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     pool_bit,
  output logic                     pool_valid,
  output logic [7:0]               pool_idx,
  output logic                     pool_done,
`ifdef MAXPOOL_RAW_OUT_EN
  output logic signed [DATA_W-1:0] pool_max,
`endif
  output logic                     overrun
);

  localparam int OUT_N  = (IN_W / 2) * (IN_H / 2);
  localparam int HALF_W = IN_W / 2;
  localparam int CW     = $clog2(IN_W);
  localparam int RW     = $clog2(IN_H);
  localparam int LAW    = CW - 1;
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  pool_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [DATA_W-1:0] pair_q, pair_d;
  logic pool_bit_q, pool_bit_d;
  logic pool_valid_q, pool_valid_d;
  logic [7:0] pool_idx_q, pool_idx_d;
  logic pool_done_q, pool_done_d;
  logic overrun_q, overrun_d;
  logic signed [DATA_W-1:0] pool_max_q, pool_max_d;

  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] quad;
  logic signed [DATA_W-1:0] lb_rdata;
  logic lb_we;
  logic lb_clr;
  logic last_col;
  logic last_px;
  logic [7:0] idx_calc;

  pool_linebuf #(
    .DEPTH  (HALF_W),
    .DATA_W (DATA_W),
    .AW     (LAW)
  ) u_linebuf (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (lb_clr),
    .we    (lb_we),
    .waddr (col_q[CW-1:1]),
    .wdata (pair_max),
    .raddr (col_q[CW-1:1]),
    .rdata (lb_rdata)
  );

  always_comb begin
    pair_max = DATA_W'(smax(SMAX_W'(pair_q), SMAX_W'(din)));
    quad     = DATA_W'(smax(SMAX_W'(pair_max), SMAX_W'(lb_rdata)));
    last_col = (col_q == CW'(IN_W - 1));
    last_px  = last_col && (row_q == RW'(IN_H - 1));
    idx_calc = 8'((int'(row_q) >> 1) * HALF_W + (int'(col_q) >> 1));
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    pool_bit_d   = pool_bit_q;
    pool_valid_d = 1'b0;
    pool_idx_d   = pool_idx_q;
    pool_done_d  = 1'b0;
    overrun_d    = overrun_q;
    pool_max_d   = pool_max_q;
    lb_we        = 1'b0;
    lb_clr       = 1'b0;

    // frame_start outranks any sample presented in the same cycle.
    if (frame_start) begin
      state_d   = ST_RUN;
      col_d     = '0;
      row_d     = '0;
      pair_d    = S_MIN;
      overrun_d = 1'b0;
      lb_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (din_valid) begin
            if (!col_q[0]) begin
              pair_d = din;
            end else if (!row_q[0]) begin
              lb_we = 1'b1;
            end else begin
              pool_valid_d = 1'b1;
              pool_bit_d   = ~quad[DATA_W-1];
              pool_max_d   = quad;
              pool_idx_d   = idx_calc;
              pool_done_d  = (idx_calc == 8'(OUT_N - 1));
            end
            if (last_px) begin
              state_d = ST_DONE;
            end else if (last_col) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (din_valid) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= S_MIN;
      pool_bit_q   <= 1'b0;
      pool_valid_q <= 1'b0;
      pool_idx_q   <= '0;
      pool_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      pool_max_q   <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      pool_bit_q   <= pool_bit_d;
      pool_valid_q <= pool_valid_d;
      pool_idx_q   <= pool_idx_d;
      pool_done_q  <= pool_done_d;
      overrun_q    <= overrun_d;
      pool_max_q   <= pool_max_d;
    end
  end

  assign pool_bit   = pool_bit_q;
  assign pool_valid = pool_valid_q;
  assign pool_idx   = pool_idx_q;
  assign pool_done  = pool_done_q;
  assign overrun    = overrun_q;

`ifdef MAXPOOL_RAW_OUT_EN
  assign pool_max = pool_max_q;
`else
  logic unused_max;
  assign unused_max = ^pool_max_q;
`endif

endmodule

// File: tb/tb_binary_maxpool.sv
// tb/tb_binary_maxpool.sv - directed, table-driven bench for binary_maxpool
module tb_binary_maxpool;

  localparam int DW = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_start = 1'b0;
  logic din_valid = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic pool_bit;
  logic pool_valid;
  logic [7:0] pool_idx;
  logic pool_done;
  logic overrun;
`ifdef MAXPOOL_RAW_OUT_EN
  logic signed [DW-1:0] pool_max;
`endif

  binary_maxpool dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .din         (din),
    .din_valid   (din_valid),
    .pool_bit    (pool_bit),
    .pool_valid  (pool_valid),
    .pool_idx    (pool_idx),
    .pool_done   (pool_done),
`ifdef MAXPOOL_RAW_OUT_EN
    .pool_max    (pool_max),
`endif
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  typedef struct {
    int idx;
    int tl;
    int tr;
    int bl;
    int br;
    int bitv;
  } win_t;

  win_t tbl[8];
  int img[576];
  int exp_bits[144];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cycle(input logic fs, input logic dv, input int v);
    @(negedge clk);
    frame_start = fs;
    din_valid   = dv;
    din         = DW'(v);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    din_valid   = 1'b0;
  endtask

  task automatic send(input int r, input int c);
    int idx;
    cycle(1'b0, 1'b1, img[r*24+c]);
    idx = (r / 2) * 12 + c / 2;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      chk("valid", int'(pool_valid), 1);
      chk("bit", int'(pool_bit), exp_bits[idx]);
      chk("idx", int'(pool_idx), idx);
      chk("done", int'(pool_done), (idx == 143) ? 1 : 0);
    end else begin
      chk("novalid", int'(pool_valid), 0);
      chk("nodone", int'(pool_done), 0);
    end
  endtask

  task automatic run_frame(input bit start, input bit gaps, input int nsamp);
    if (start) begin
      cycle(1'b1, 1'b0, 0);
      chk("ovr_clr", int'(overrun), 0);
    end
    for (int k = 0; k < nsamp; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          cycle(1'b0, 1'b0, 0);
          chk("gap_novalid", int'(pool_valid), 0);
        end
      end
      send(k / 24, k % 24);
    end
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < 576; i++) img[i] = v;
    for (int i = 0; i < 144; i++) exp_bits[i] = (v >= 0) ? 1 : 0;
  endtask

  task automatic set_table();
    int base;
    for (int i = 0; i < 576; i++) img[i] = -1;
    for (int i = 0; i < 144; i++) exp_bits[i] = 0;
    for (int t = 0; t < 8; t++) begin
      base = (tbl[t].idx / 12) * 48 + (tbl[t].idx % 12) * 2;
      img[base]      = tbl[t].tl;
      img[base + 1]  = tbl[t].tr;
      img[base + 24] = tbl[t].bl;
      img[base + 25] = tbl[t].br;
      exp_bits[tbl[t].idx] = tbl[t].bitv;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(pool_valid), 0);
    chk({tag, "_bit"}, int'(pool_bit), 0);
    chk({tag, "_idx"}, int'(pool_idx), 0);
    chk({tag, "_done"}, int'(pool_done), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    tbl[0] = '{14,  -1,  -1,   0,  -1, 1};
    tbl[1] = '{0,  -16, -16, -16,  -1, 0};
    tbl[2] = '{1,  -16,  15, -16, -16, 1};
    tbl[3] = '{143,-16, -16, -16,   0, 1};
    tbl[4] = '{11,   5,  -3,  -8,  -2, 1};
    tbl[5] = '{12,  -2,  -3,  -4,  -5, 0};
    tbl[6] = '{70, -16, -16, -16, -16, 0};
    tbl[7] = '{100, 15,  15,  15,  15, 1};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 3);
      chk("idle_novalid", int'(pool_valid), 0);
      chk("idle_noovr", int'(overrun), 0);
    end

    set_const(3);
    run_frame(1'b1, 1'b0, 576);
    cycle(1'b0, 1'b1, 3);
    chk("extra_novalid", int'(pool_valid), 0);
    chk("extra_nodone", int'(pool_done), 0);
    chk("extra_ovr", int'(overrun), 1);

    set_table();
    run_frame(1'b1, 1'b0, 576);
    run_frame(1'b1, 1'b1, 576);

    run_frame(1'b1, 1'b0, 100);
    run_frame(1'b1, 1'b0, 576);

    run_frame(1'b1, 1'b0, 300);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 5);
      chk("postrst_novalid", int'(pool_valid), 0);
      chk("postrst_noovr", int'(overrun), 0);
    end

    cycle(1'b1, 1'b1, 15);
    run_frame(1'b0, 1'b0, 576);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
